// File: rtl/insert_sort.sv
// Stable insertion sorter: one compare/swap per clock over a captured array.
// Define INSERT_SORT_DESCENDING_EN for descending order (default ascending).
module insert_sort #(
    parameter int RSTPOL         = 0,
    parameter int INPUTVALS      = 16,
    parameter int INPUTBITWIDTHS = 6
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           sortstart,
    input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]       needs_sorting,
    output logic                                           sortdone,
    output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]       sorted,
    output logic [INPUTVALS-1:0][$clog2(INPUTVALS):0]      sorted_positions,
    output logic                                           error
);

    localparam int N  = INPUTVALS;
    localparam int W  = INPUTBITWIDTHS;
    localparam int IW = $clog2(N);
    localparam int P  = IW + 1;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                 state;
    logic [N-1:0][W-1:0]    work;
    logic [N-1:0][P-1:0]    pos;
    logic [IW-1:0]          i;
    logic [IW-1:0]          j;

    logic                   rst_n;
    logic [IW-1:0]          jm1;
    logic [IW-1:0]          i_nx;
    logic [W-1:0]           lo_val;
    logic [W-1:0]           hi_val;
    logic [P-1:0]           lo_pos;
    logic [P-1:0]           hi_pos;
    logic                   out_of_order;
    logic                   swap;
    logic                   last;

    assign rst_n = (RSTPOL == 0) ? reset : ~reset;

    assign jm1    = j - ONE;
    assign i_nx   = i + ONE;
    assign lo_val = work[jm1];
    assign hi_val = work[j];
    assign lo_pos = pos[jm1];
    assign hi_pos = pos[j];
    assign last   = (i == LAST);

`ifdef INSERT_SORT_DESCENDING_EN
    assign out_of_order = (lo_val < hi_val);
`else
    assign out_of_order = (lo_val > hi_val);
`endif

    // j == 0 means the element reached the front: treat as a no-swap cycle
    assign swap = (j != '0) && out_of_order;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            work             <= '0;
            pos              <= '0;
            i                <= '0;
            j                <= '0;
            sortdone         <= 1'b0;
            error            <= 1'b0;
            sorted           <= '0;
            sorted_positions <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (sortstart) begin
                        work <= needs_sorting;
                        for (int k = 0; k < N; k++) begin
                            pos[k] <= P'(k);
                        end
                        i        <= ONE;
                        j        <= ONE;
                        sortdone <= 1'b0;
                        error    <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (sortstart) begin
                        error <= 1'b1;
                    end
                    if (swap) begin
                        work[jm1] <= hi_val;
                        work[j]   <= lo_val;
                        pos[jm1]  <= hi_pos;
                        pos[j]    <= lo_pos;
                        j         <= jm1;
                    end else if (last) begin
                        sorted           <= work;
                        sorted_positions <= pos;
                        sortdone         <= 1'b1;
                        state            <= DONE;
                    end else begin
                        i <= i_nx;
                        j <= i_nx;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insert_sort.sv
// Bench for insert_sort: directed cases plus random runs against a rank-based
// reference sort with inversion-count latency.
module tb_insert_sort;

    localparam int N = 16;
    localparam int W = 6;
    localparam int P = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sortstart;
    logic [N-1:0][W-1:0]   needs_sorting;
    logic                  sortdone;
    logic [N-1:0][W-1:0]   sorted;
    logic [N-1:0][P-1:0]   sorted_positions;
    logic                  error;

    int tests = 0;
    int fails = 0;

    logic [W-1:0]          vals [N];
    logic [N-1:0][W-1:0]   exp_sorted;
    logic [N-1:0][P-1:0]   exp_pos;
    logic [N-1:0][W-1:0]   last_sorted;
    logic [N-1:0][P-1:0]   last_pos;
    int                    exp_lat;

    insert_sort #(
        .RSTPOL         (0),
        .INPUTVALS      (N),
        .INPUTBITWIDTHS (W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sortstart        (sortstart),
        .needs_sorting    (needs_sorting),
        .sortdone         (sortdone),
        .sorted           (sorted),
        .sorted_positions (sorted_positions),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // true when a must come strictly before b in the output order
    function automatic bit ahead(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef INSERT_SORT_DESCENDING_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    task automatic model();
        int inv;
        inv = 0;
        for (int k = 0; k < N; k++) begin
            int rank;
            rank = 0;
            for (int m = 0; m < N; m++) begin
                if (ahead(vals[m], vals[k]) || (vals[m] == vals[k] && m < k))
                    rank++;
                if (m > k && ahead(vals[m], vals[k]))
                    inv++;
            end
            exp_sorted[rank] = vals[k];
            exp_pos[rank]    = P'(k);
        end
        exp_lat = (N - 1) + inv;
    endtask

    task automatic run_sort(input string tag, input bit inject);
        int cnt;
        bit seen;
        model();
        @(negedge clk);
        for (int k = 0; k < N; k++) needs_sorting[k] = vals[k];
        sortstart = 1'b1;
        @(posedge clk);
        #1;
        sortstart = 1'b0;
        for (int k = 0; k < N; k++) needs_sorting[k] = W'($urandom);
        check({tag, "/start_sortdone"}, sortdone, 0);
        check({tag, "/start_error"}, error, 0);
        check({tag, "/start_sorted_kept"}, sorted, last_sorted);
        check({tag, "/start_pos_kept"}, sorted_positions, last_pos);
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 400) begin
            @(posedge clk);
            cnt++;
            #1;
            if (inject && cnt == 2) sortstart = 1'b1;
            if (inject && cnt == 3) begin
                sortstart = 1'b0;
                check({tag, "/error_set"}, error, 1);
            end
            seen = sortdone;
        end
        check({tag, "/done_seen"}, seen, 1);
        check({tag, "/latency"}, cnt, exp_lat);
        check({tag, "/sorted"}, sorted, exp_sorted);
        check({tag, "/positions"}, sorted_positions, exp_pos);
        check({tag, "/error_end"}, error, inject);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "/hold_done"}, sortdone, 1);
        check({tag, "/hold_sorted"}, sorted, exp_sorted);
        last_sorted = exp_sorted;
        last_pos    = exp_pos;
    endtask

    initial begin
        reset         = 1'b0;
        sortstart     = 1'b0;
        needs_sorting = '0;
        last_sorted   = '0;
        last_pos      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/sortdone", sortdone, 0);
        check("reset/error", error, 0);
        check("reset/sorted", sorted, 0);
        check("reset/positions", sorted_positions, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < N; k++) vals[k] = W'(k);
        run_sort("ascending", 1'b0);

        for (int k = 0; k < N; k++) vals[k] = W'(N - 1 - k);
        run_sort("reverse", 1'b0);

        vals[0] = 6'd5; vals[1] = 6'd3; vals[2] = 6'd5; vals[3] = 6'd3;
        vals[4] = 6'd0;
        for (int k = 5; k < N; k++) vals[k] = 6'd63;
        run_sort("dups", 1'b0);

        for (int k = 0; k < N; k++) vals[k] = W'(N - 1 - k);
        run_sort("err_pulse", 1'b1);
        for (int k = 0; k < N; k++) vals[k] = W'($urandom);
        run_sort("err_clear", 1'b0);

        // abort a sort mid-SCAN with an asynchronous reset
        for (int k = 0; k < N; k++) vals[k] = W'(N - 1 - k);
        @(negedge clk);
        for (int k = 0; k < N; k++) needs_sorting[k] = vals[k];
        sortstart = 1'b1;
        @(posedge clk);
        #1;
        sortstart = 1'b0;
        @(posedge clk);
        sortstart = 1'b1;
        @(posedge clk);
        #1;
        sortstart = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset/sortdone", sortdone, 0);
        check("midreset/error", error, 0);
        check("midreset/sorted", sorted, 0);
        check("midreset/positions", sorted_positions, 0);
        @(negedge clk);
        reset       = 1'b1;
        last_sorted = '0;
        last_pos    = '0;
        for (int k = 0; k < N; k++) vals[k] = W'($urandom);
        run_sort("after_reset", 1'b0);

        for (int r = 0; r < 100; r++) begin
            for (int k = 0; k < N; k++) vals[k] = W'($urandom_range(0, 63));
            run_sort($sformatf("rand%0d", r), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/insert_sort.md
INSERT_SORT -- requirements
Module: insert_sort

Interface
REQ-001 The module SHALL have parameter RSTPOL, default 0, giving the reset level at which reset is asserted; 0 is the only supported value.
REQ-002 The module SHALL have parameter INPUTVALS, default 16, giving the number of elements N, with N >= 2.
REQ-003 The module SHALL have parameter INPUTBITWIDTHS, default 6, giving the element width W, with W >= 1.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port sortstart, input, 1 bit: single-cycle start request.
REQ-007 The module SHALL have port needs_sorting, input, packed [N-1:0][W-1:0]: the unsorted elements, with element k at index k.
REQ-008 The module SHALL have port sortdone, output, 1 bit: result valid, as a level.
REQ-009 The module SHALL have port sorted, output, packed [N-1:0][W-1:0]: the sorted elements, with index 0 holding the first element in sort order.
REQ-010 The module SHALL have port sorted_positions, output, packed [N-1:0][$clog2(N):0]: the original needs_sorting index of each sorted element.
REQ-011 The module SHALL have port error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 Elements SHALL be unsigned and sorted ascending.
- The sort SHALL be stable: equal values keep their original relative order.
REQ-013 States SHALL be IDLE, SCAN and DONE.
REQ-014 Start acceptance: sortstart high at a rising edge while in IDLE or DONE SHALL do all of the following at that edge (E0):
- capture needs_sorting into a working array;
- load the position array with 0..N-1;
- set i=1 and j=1;
- clear sortdone and clear error;
- enter SCAN.
REQ-015 SCAN SHALL perform one compare per cycle between elements j-1 and j.
- If work[j-1] > work[j] (strictly greater), the two elements and their positions SHALL be swapped and j SHALL decrement.
- Otherwise, i and j SHALL both be set to i+1.
REQ-016 When j reaches 0, the next cycle SHALL be treated as a no-swap cycle and SHALL advance i as in REQ-015.
REQ-017 A no-swap cycle with i = N-1 SHALL enter DONE on that edge, which ends the sort.
- On that same edge, the working array SHALL be copied to sorted, the position array to sorted_positions, and sortdone SHALL be set to 1.
REQ-018 Latency: sortdone SHALL rise on the C-th rising edge after E0, where C = (N-1) + (number of inversions in the input).
- Best case is N-1 edges; worst case is (N-1) + N(N-1)/2 edges.
REQ-019 sortdone, sorted and sorted_positions SHALL hold their values in DONE until the next accepted sortstart.
- At that accepted sortstart, only sortdone clears; sorted and sorted_positions keep their old values until the new result is loaded.
REQ-020 sortstart high while in SCAN SHALL be ignored (no restart, inputs not captured) and SHALL set error to 1.
- error SHALL remain 1 until reset or the next accepted sortstart.
REQ-021 Changes on needs_sorting after E0 SHALL NOT affect the sort in progress.
REQ-022 Position values SHALL be zero-extended to $clog2(N)+1 bits.

Reset
REQ-023 Asserting reset (reset = 0) SHALL act asynchronously, including mid-sort, and SHALL force:
- state to IDLE;
- sortdone = 0 and error = 0;
- sorted and sorted_positions to all zeros;
- all working registers and counters to zero.
REQ-024 After reset deasserts, the first sortstart SHALL be accepted normally.

Configuration
REQ-025 When macro INSERT_SORT_DESCENDING_EN is defined, the order SHALL be descending: the swap condition becomes work[j-1] < work[j] (strictly less), and stability and latency rules are unchanged with inversions counted for descending order.
- When the macro is undefined, the order SHALL be ascending as in REQ-012.

Verification (N=16, W=6)
REQ-026 Already-sorted input 0,1,...,15 -> sortdone rises 15 edges after E0; sorted = 0..15; sorted_positions = 0..15; error = 0.
REQ-027 Reverse input 15,14,...,0 -> sortdone rises 135 edges after E0; sorted = 0..15; sorted_positions = 15,14,...,0.
REQ-028 Duplicates: input 5,3,5,3,0 followed by eleven 63s -> sorted = 0,3,3,5,5,63,... and sorted_positions = 4,1,3,0,2,5,6,...,15 (stability check).
REQ-029 sortstart pulsed 3 cycles after E0 -> error = 1; the original sort completes with a correct result; the next accepted sortstart clears error.
REQ-030 Reset asserted mid-SCAN -> sortdone, error, sorted and sorted_positions read 0 immediately, before the next clock edge; a new sort after release completes correctly.
REQ-031 Random inputs (e.g. 100 runs, values drawn from 0..63) -> sorted equals a reference sort; sorted_positions is a permutation satisfying sorted[k] == needs_sorting[sorted_positions[k]]; latency matches REQ-018.
